// File: rtl/pad_scan_pkg.sv
// Purpose: shared defaults, widths and event layout for the 4x4 pad scanner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pad_scan_pkg;

    localparam int SCAN_DIV_DEF = 1000;   // cycles each row is driven
    localparam int DEBOUNCE_DEF = 3;      // disagreeing scans needed to flip a key

    localparam int NUM_ROWS   = 4;
    localparam int NUM_COLS   = 4;
    localparam int NUM_KEYS   = NUM_ROWS * NUM_COLS;

    localparam int EV_W       = 5;
    localparam int FIFO_DEPTH = 4;

    // Event field positions: bit4 = press(1)/release(0), bits3:0 = key index.
    localparam int EV_PRESS_BIT = 4;
    localparam int EV_KEY_LSB   = 0;
    localparam int EV_KEY_W     = 4;

    typedef struct packed {
        logic       press;
        logic [3:0] key;     // row*4 + col
    } ev_t;

    function automatic ev_t make_ev(input logic press, input logic [1:0] row,
                                    input logic [1:0] col);
        ev_t ev;
        ev.press = press;
        ev.key   = {row, col};
        return ev;
    endfunction

endpackage

// File: rtl/pad_event_fifo.sv
// Purpose: small FIFO holding key events until the consumer takes them.
// Latency: 1 cycle from push to data visible at the head (empty deasserts next cycle).
// Backpressure: push into a full FIFO without a same-cycle pop is dropped and flagged on drop.
//
// Ports: clk/rst_n (sync, active-low); push/push_data write side; pop read side
// (ignored when empty); full/empty status; data = head entry (zero when empty);
// drop = combinational pulse for a rejected push.
module pad_event_fifo
    import pad_scan_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,   // must be a power of two (pointers wrap naturally)
    parameter int W     = EV_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] data,
    output logic         drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign data    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pad_scan_ctrl.sv
// Purpose: 4x4 key pad scanner with per-key debounce and a press/release event queue.
// Latency: event queued at the evaluation cycle of its column, ev_valid one cycle later.
// Backpressure: ev_valid/ev_ready handshake; events arriving at a full queue are dropped, overflow sticks.
//
// Ports: clk, rst_n (sync, active-low); enable freezes scanning; col_in raw column
// returns (async); row_sel drives the row decoder; ev_valid/ev_data/ev_ready event
// stream; key_state debounced map (bit = row*4+col); overflow sticky, clr_ovf clears.
module pad_scan_ctrl
    import pad_scan_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEF,   // >= 8
    parameter int DEBOUNCE = DEBOUNCE_DEF    // 1..15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [NUM_COLS-1:0] col_in,
    output logic [1:0]          row_sel,
    output logic                ev_valid,
    output logic [EV_W-1:0]     ev_data,
    input  logic                ev_ready,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                overflow,
    input  logic                clr_ovf
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(SCAN_DIV - 5);
    localparam logic [CNT_W-1:0] EVAL_BASE = CNT_W'(SCAN_DIV - 4);
    localparam logic [3:0]       DEB_LAST  = 4'(DEBOUNCE - 1);

    logic [NUM_COLS-1:0] sync_a;
    logic [NUM_COLS-1:0] sync_b;
    logic [NUM_COLS-1:0] col_sample;
    logic [CNT_W-1:0]    cnt;
    logic [3:0]          dbc [NUM_KEYS];

    // Column evaluation occupies the last four cycles of each row period,
    // one column per cycle, so the decoder output has long settled.
    logic       in_eval;
    logic [1:0] eval_col;
    logic [3:0] eval_key;
    logic       eval_sample;
    logic       eval_differs;
    logic       eval_flip;

    logic       fifo_push;
    ev_t        fifo_push_data;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_drop;

    assign in_eval      = enable && (cnt >= EVAL_BASE);
    assign eval_col     = 2'(cnt - EVAL_BASE);
    assign eval_key     = {row_sel, eval_col};
    assign eval_sample  = col_sample[eval_col];
    assign eval_differs = (eval_sample != key_state[eval_key]);
    // The scan that would bring the counter up to DEBOUNCE flips the key instead.
    assign eval_flip    = eval_differs && (dbc[eval_key] == DEB_LAST);

    assign fifo_push      = in_eval && eval_flip;
    assign fifo_push_data = make_ev(eval_sample, row_sel, eval_col);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a     <= '0;
            sync_b     <= '0;
            col_sample <= '0;
            cnt        <= '0;
            row_sel    <= '0;
            key_state  <= '0;
            overflow   <= 1'b0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                dbc[k] <= '0;
            end
        end else begin
            // Synchronizer runs regardless of enable so it is primed on resume.
            sync_a <= col_in;
            sync_b <= sync_a;

            if (enable) begin
                if (cnt == CNT_LAST) begin
                    cnt     <= '0;
                    row_sel <= row_sel + 2'd1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end

                if (cnt == SAMPLE_AT) begin
                    col_sample <= sync_b;
                end

                if (in_eval) begin
                    if (!eval_differs) begin
                        dbc[eval_key] <= '0;
                    end else if (eval_flip) begin
                        key_state[eval_key] <= eval_sample;
                        dbc[eval_key]       <= '0;
                    end else begin
                        dbc[eval_key] <= dbc[eval_key] + 4'd1;
                    end
                end
            end

            // A drop wins over a simultaneous clear so no loss goes unreported.
            if (fifo_drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    pad_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EV_W)
    ) u_event_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (ev_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .data      (ev_data),
        .drop      (fifo_drop)
    );

    assign ev_valid = !fifo_empty;

    drop_only_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_drop |-> fifo_full);

endmodule

// File: doc/pad_scan_ctrl.md
PAD_SCAN_CTRL -- requirements
Module: pad_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each row is driven; SHALL be >= 8.
REQ-002 Parameter DEBOUNCE, default 3: consecutive disagreeing scans needed to flip a key state; SHALL be 1..15.
REQ-003 Port clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port enable, input, 1: scan enable; low freezes the cycle counter, row and debounce state.
REQ-006 Port col_in, input, 4: pad column returns, active-high pressed, asynchronous to clk.
REQ-007 Port row_sel, output, 2: binary row index feeding the downstream 2-to-4 row decoder.
REQ-008 Port ev_valid, output, 1: event FIFO not empty.
REQ-009 Port ev_data, output, 5: head event; bit4 = 1 press / 0 release, bits3:0 = key index.
REQ-010 Port ev_ready, input, 1: consumer accepts the head event when ev_valid and ev_ready are both high.
REQ-011 Port key_state, output, 16: debounced state per key, bit = row*4+col.
REQ-012 Port overflow, output, 1: sticky flag, set when an event is dropped.
REQ-013 Port clr_ovf, input, 1: clears overflow.

Function
REQ-014 col_in SHALL pass through a 2-flop synchronizer before any use.
REQ-015 Cycle counter cnt SHALL count 0..SCAN_DIV-1 while enable is high; at wrap, row_sel SHALL increment mod 4 (3 -> 0).
REQ-016 At cnt == SCAN_DIV-5, the synchronized columns SHALL be captured into col_sample.
REQ-017 At cnt == SCAN_DIV-4+c (c = 0..3), column c of the current row SHALL be evaluated, one column per cycle.
REQ-018 Evaluation SHALL compare sample against key_state: if they agree, that key's debounce counter resets to 0; if they differ, the counter increments.
REQ-019 When a counter reaches DEBOUNCE, key_state SHALL take the sample value, the counter SHALL reset to 0, and one event {sample, key index} SHALL be pushed.
REQ-020 The event FIFO SHALL be 4 entries deep and first-in first-out; ev_valid SHALL rise 1 cycle after a push into the empty FIFO.
REQ-021 A push while the FIFO is full and no pop occurs SHALL drop the new event and set overflow in the same cycle; existing entries SHALL be unchanged.
REQ-022 A push and pop in the same cycle SHALL both take effect, including when the FIFO is full (no drop).
REQ-023 A pop while the FIFO is empty SHALL have no effect.
REQ-024 If clr_ovf and a drop occur in the same cycle, overflow SHALL remain set.
REQ-025 With enable low, the FIFO SHALL still drain via ev_ready, and the synchronizer SHALL keep running.
REQ-026 A key change shorter than DEBOUNCE scans SHALL produce no event and leave key_state unchanged.

Reset
REQ-027 With rst_n low at a clock edge, the block SHALL set cnt = 0, row_sel = 0, all debounce counters = 0, key_state = 0, col_sample = 0, synchronizer = 0, FIFO empty (ev_valid = 0, ev_data = 0) and overflow = 0.
REQ-028 Reset mid-scan or mid-event SHALL discard all pending events and partial debounce counts; scanning SHALL restart at row 0, cnt 0 on the first cycle after rst_n returns high.

Structure
REQ-029 Package pad_scan_pkg SHALL hold the SCAN_DIV/DEBOUNCE defaults, EV_W = 5, FIFO_DEPTH = 4 and the event field positions.
REQ-030 The FIFO SHALL be the sub-module pad_event_fifo (push, pop, full, empty, data, drop); scan, debounce and synchronizer logic SHALL stay in pad_scan_ctrl.

Verification (bench: SCAN_DIV = 16, DEBOUNCE = 3)
REQ-031 Reset then enable for 64 cycles -> row_sel steps 0,1,2,3,0 every 16 cycles; ev_valid = 0; key_state = 0.
REQ-032 Hold col_in = 4'b0100 while row 2 is driven, for 3 scans, with ev_ready = 1 -> one event 5'b1_1010; key_state[10] = 1.
REQ-033 Release key 10 for 3 scans -> one event 5'b0_1010; key_state[10] = 0.
REQ-034 Assert col 1 for 2 scans only -> no event; key_state unchanged.
REQ-035 With ev_ready = 0, press 5 distinct keys -> 4 events held in order; overflow = 1; clr_ovf then clears it; draining yields the first 4 events in order.
REQ-036 Pulse rst_n low while an event is pending and key 10 has a count of 2 -> ev_valid = 0, overflow = 0, row_sel = 0; key 10 then needs a full 3 scans to produce an event.
